// File: rtl/timer_irq.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a maskable interrupt.
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only); irq = PEND & IM.
`timescale 1ns/1ps
module timer_irq #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [1:0]       state;
   logic             en;
   logic [1:0]       mode;
   logic             im;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic             pend;

   logic             wr_ctrl;
   logic             wr_preset;
   logic             en_wr;
   logic             auto_reload;
   logic             expire;

   assign wr_ctrl     = we && (addr == 2'd0);
   assign wr_preset   = we && (addr == 2'd1);
   // EN as it will stand after this edge, so LOAD/INT can leave for IDLE directly
   assign en_wr       = wr_ctrl ? wdata[0] : en;
   assign auto_reload = (mode == 2'b01);
   assign expire      = (state == S_CNT) && en && (count <= ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         en     <= 1'b0;
         mode   <= 2'b00;
         im     <= 1'b0;
         preset <= '0;
         count  <= '0;
         pend   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
               pend  <= 1'b0;
               state <= en_wr ? S_CNT : S_IDLE;
            end
            S_CNT: begin
               if (!en) begin
                  state <= S_IDLE;
               end else if (count > ONE) begin
                  count <= count - ONE;
               end else begin
                  count <= '0;
                  pend  <= 1'b1;
                  state <= S_INT;
               end
            end
            S_INT: begin
               if (auto_reload) begin
                  pend  <= 1'b0;
                  state <= en_wr ? S_LOAD : S_IDLE;
               end else begin
                  en    <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Placed after the FSM so a CTRL write overrides the one-shot EN clear
         if (wr_ctrl) begin
            en   <= wdata[0];
            mode <= wdata[2:1];
            im   <= wdata[3];
            if (!expire) pend <= 1'b0;
         end
         if (wr_preset) preset <= wdata[CNT_W-1:0];
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0:    rdata = {28'd0, im, mode, en};
         2'd1:    rdata = 32'(preset);
         2'd2:    rdata = 32'(count);
         default: rdata = '0;
      endcase
   end

   assign irq = pend & im;

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed vector table, hand-written corner sequences,
// and randomized bus traffic checked against a cycle model of the register/timer rules.
`timescale 1ns/1ps
module tb_timer_irq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   timer_irq #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vt[17];

   // Reference model state
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
   logic        m_en, m_im, m_pend;
   logic [1:0]  m_mode;
   logic [31:0] m_pre, m_cnt;
   int          m_ph;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic look(input logic [1:0] a, input string name, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rdata, exp);
   endtask

   task automatic do_reset();
      we = 1'b0; addr = 2'd0; wdata = '0;
      @(negedge clk);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_pre;
         2'd2:    return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_im = 0; m_pend = 0; m_mode = 0; m_pre = 0; m_cnt = 0; m_ph = PH_IDLE;
   endtask

   // Advance the model across one rising edge with the given bus inputs.
   task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
      logic ctrl_w, en_after, fired;
      int   ph;
      ctrl_w   = w && (a == 2'd0);
      en_after = ctrl_w ? d[0] : m_en;
      fired    = 1'b0;
      ph       = m_ph;
      if (m_ph == PH_IDLE) begin
         if (m_en) ph = PH_LOAD;
      end else if (m_ph == PH_LOAD) begin
         m_cnt = m_pre; m_pend = 1'b0;
         ph = en_after ? PH_CNT : PH_IDLE;
      end else if (m_ph == PH_CNT) begin
         if (!m_en) ph = PH_IDLE;
         else if (m_cnt >= 32'd2) m_cnt = m_cnt - 32'd1;
         else begin m_cnt = 32'd0; m_pend = 1'b1; fired = 1'b1; ph = PH_INT; end
      end else begin
         if (m_mode == 2'b01) begin
            m_pend = 1'b0;
            ph = en_after ? PH_LOAD : PH_IDLE;
         end else begin
            m_en = 1'b0; ph = PH_IDLE;
         end
      end
      if (ctrl_w) begin
         m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
         if (!fired) m_pend = 1'b0;
      end
      if (w && a == 2'd1) m_pre = d;
      m_ph = ph;
   endtask

   initial begin
      int  pulses, found;
      logic seen;
      logic [1:0]  r_addr;
      logic        r_we;
      logic [31:0] r_wd;

      reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
      #1;

      // Reset state
      do_reset();
      look(2'd0, "reset ctrl", 32'd0);
      look(2'd1, "reset preset", 32'd0);
      look(2'd2, "reset count", 32'd0);
      look(2'd3, "reset rsvd", 32'd0);
      chk("reset irq", 32'(irq), 32'd0);

      // One-shot with PRESET=5 plus write-ignore checks
      vt[0]  = '{1'b1, 2'd1, 32'd5,          32'd0, 1'b0};
      vt[1]  = '{1'b1, 2'd0, 32'h9,          32'd0, 1'b0};
      vt[2]  = '{1'b0, 2'd2, 32'd0,          32'd0, 1'b0};
      vt[3]  = '{1'b0, 2'd2, 32'd0,          32'd0, 1'b0};
      vt[4]  = '{1'b0, 2'd2, 32'd0,          32'd5, 1'b0};
      vt[5]  = '{1'b0, 2'd2, 32'd0,          32'd4, 1'b0};
      vt[6]  = '{1'b0, 2'd2, 32'd0,          32'd3, 1'b0};
      vt[7]  = '{1'b0, 2'd2, 32'd0,          32'd2, 1'b0};
      vt[8]  = '{1'b0, 2'd2, 32'd0,          32'd1, 1'b0};
      vt[9]  = '{1'b0, 2'd2, 32'd0,          32'd0, 1'b1};
      vt[10] = '{1'b0, 2'd0, 32'd0,          32'h8, 1'b1};
      vt[11] = '{1'b1, 2'd0, 32'h8,          32'h8, 1'b1};
      vt[12] = '{1'b0, 2'd0, 32'd0,          32'h8, 1'b0};
      vt[13] = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'd0, 1'b0};
      vt[14] = '{1'b1, 2'd2, 32'h55,         32'd0, 1'b0};
      vt[15] = '{1'b0, 2'd2, 32'd0,          32'd0, 1'b0};
      vt[16] = '{1'b0, 2'd1, 32'd0,          32'd5, 1'b0};
      for (int i = 0; i < 17; i++) begin
         we = vt[i].we; addr = vt[i].addr; wdata = vt[i].wdata;
         #1;
         chk($sformatf("vec%0d rdata", i), rdata, vt[i].exp_rd);
         chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vt[i].exp_irq));
         tick();
      end
      we = 1'b0;

      // Auto-reload, PRESET=3: five-cycle period
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      pulses = 0;
      for (int k = 1; k <= 21; k++) begin
         int p;
         tick();
         addr = 2'd2;
         #1;
         p = (k - 2) % 5;
         if (k == 1) chk($sformatf("auto k%0d count", k), rdata, 32'd0);
         else chk($sformatf("auto k%0d count", k), rdata, (p <= 2) ? 32'(3 - p) : 32'd0);
         chk($sformatf("auto k%0d irq", k), 32'(irq), 32'((k >= 2) && (p == 3)));
         if (irq) pulses++;
      end
      chk("auto pulse count", 32'(pulses), 32'd4);

      // Disable mid-count freezes COUNT; re-enable reloads
      do_reset();
      wr(2'd1, 32'h100);
      wr(2'd0, 32'h9);
      found = 0; seen = 1'b0;
      addr = 2'd2;
      for (int i = 0; i < 400 && found == 0; i++) begin
         tick();
         #1;
         seen = seen | irq;
         if (rdata == 32'h80) found = 1;
      end
      chk("freeze reach 0x80", 32'(found), 32'd1);
      wr(2'd0, 32'h8);
      tick();
      for (int i = 0; i < 4; i++) begin
         look(2'd2, "freeze count", 32'h7F);
         seen = seen | irq;
         tick();
      end
      wr(2'd0, 32'h9);
      tick();
      tick();
      look(2'd2, "reload count", 32'h100);
      seen = seen | irq;
      chk("freeze irq never", 32'(seen), 32'd0);

      // Masked one-shot: CTRL write clears PEND before IM goes high
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); seen = seen | irq; end
      look(2'd0, "masked ctrl after oneshot", 32'd0);
      wr(2'd0, 32'h8);
      for (int i = 0; i < 4; i++) begin tick(); seen = seen | irq; end
      chk("masked irq stays low", 32'(seen), 32'd0);

      // CTRL write coinciding with one-shot EN clear keeps written EN
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      tick(); tick(); tick();
      chk("race irq at E3", 32'(irq), 32'd1);
      wr(2'd0, 32'h9);
      look(2'd0, "race ctrl kept", 32'h9);
      chk("race pend cleared", 32'(irq), 32'd0);
      tick(); tick();
      chk("race irq before E7", 32'(irq), 32'd0);
      tick();
      chk("race irq after E7", 32'(irq), 32'd1);

      // Asynchronous reset between edges mid-count
      do_reset();
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(); tick(); tick(); tick();
      #2;
      reset = 1'b1;
      addr = 2'd2;
      #1;
      chk("async count", rdata, 32'd0);
      chk("async irq", 32'(irq), 32'd0);
      addr = 2'd0;
      #1;
      chk("async ctrl", rdata, 32'd0);
      #1;
      reset = 1'b0;
      we = 1'b1; addr = 2'd1; wdata = 32'd7;
      tick();
      we = 1'b0;
      look(2'd1, "first write after reset", 32'd7);
      seen = 1'b0;
      addr = 2'd2;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen = seen | irq | (rdata != 32'd0);
      end
      chk("idle after reset", 32'(seen), 32'd0);

      // Randomized traffic against the model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         r_we   = ($urandom_range(0, 9) < 2);
         r_addr = 2'($urandom_range(0, 3));
         if (r_addr == 2'd1) r_wd = 32'($urandom_range(0, 6));
         else r_wd = ($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
         we = r_we; addr = r_addr; wdata = r_wd;
         #1;
         chk($sformatf("rand c%0d rdata a%0d", cyc, r_addr), rdata, m_read(r_addr));
         chk($sformatf("rand c%0d irq", cyc), 32'(irq), 32'(m_pend & m_im));
         model_step(r_we, r_addr, r_wd);
         tick();
      end
      we = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 Parameter: CNT_W, 32, width of PRESET and COUNT registers (legal range 2..32; read data zero-extended to 32 bits).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 Port: we  input  1  write strobe, sampled on rising clk.
REQ-006 Port: wdata  input  32  write data.
REQ-007 Port: rdata  output  32  combinational read data for addr.
REQ-008 Port: irq  output  1  interrupt request to the mips core's interrupt input.

Function
REQ-009 CTRL SHALL hold: bit0 EN (enable), bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (irq mask), bits31:4 read as 0.
REQ-010 Write with we=1 SHALL update CTRL (bits3:0) or PRESET (low CNT_W bits) on the same edge; writes to COUNT or addr 3 SHALL be ignored.
REQ-011 rdata SHALL return CTRL, PRESET, COUNT, or 0 for addr 0/1/2/3 respectively, with no cycle latency.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD on next edge; else stay; COUNT held.
REQ-014 LOAD: COUNT <= PRESET; PEND <= 0; -> CNT.
REQ-015 CNT: EN=0 -> IDLE with COUNT frozen; else if COUNT>1, COUNT <= COUNT-1 and stay; else (COUNT 0 or 1) COUNT <= 0, PEND <= 1, -> INT.
REQ-016 INT, MODE=01: -> LOAD next edge (PEND therefore high exactly one cycle per period).
REQ-017 INT, MODE=00: EN <= 0, -> IDLE; PEND stays 1 until any CTRL write or reset.
REQ-018 irq SHALL equal PEND AND IM, registered-state only (no combinational path from we/wdata).
REQ-019 Latency: PRESET=N>=1, CTRL write with EN=1 at edge E0 -> irq high after edge E0+N+2; PRESET=0 behaves as N=1.
REQ-020 PRESET writes during CNT SHALL not affect COUNT until next LOAD.
REQ-021 CTRL write in the same cycle the FSM clears EN (INT, one-shot) SHALL win: written EN value persists.
REQ-022 CTRL write with EN=0 while in LOAD or INT SHALL still complete that state's action, then go to IDLE.
REQ-023 COUNT SHALL never wrap below 0.

Reset
REQ-024 On reset assertion, immediately and regardless of clk: CTRL=0, PRESET=0, COUNT=0, PEND=0, state=IDLE, irq=0.
REQ-025 Reset asserted mid-count SHALL abort counting; after deassertion the timer SHALL stay IDLE until EN is rewritten.
REQ-026 First write after reset deassertion SHALL be honoured on the first rising edge.

Verification
REQ-027 Reset pulse, then read addr 0/1/2/3 -> rdata 0,0,0,0; irq=0.
REQ-028 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 5,4,3,2,1,0; irq rises after E0+7 and stays high; CTRL reads 0x8; writing CTRL=0x8 drops irq next edge.
REQ-029 PRESET=3, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulse every 5 cycles (3 count + INT + LOAD) for 4 periods; COUNT reloads to 3.
REQ-030 PRESET=0x100, count to 0x80, write CTRL=0 -> COUNT frozen at 0x7F or 0x80 per REQ-015 edge; rewrite EN -> reload from 0x100, irq never asserted meanwhile.
REQ-031 IM=0, one-shot PRESET=2 -> irq stays 0, PEND visible by later setting IM=1? No: CTRL write clears PEND, so irq stays 0 -> check.
REQ-032 Assert reset for 0.3 clk mid-count (asynchronous, between edges) -> rdata/irq zero immediately; no activity afterwards without new EN write.
